// File: rtl/uart_pkg.sv
// Shared definitions for the FIFO-fed UART transmitter: state encoding,
// parameter legality checks and a frame-length helper.
package uart_pkg;

`ifdef UART_TX_PARITY_EN
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } uart_state_e;
`else
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_START = 3'd1,
      ST_DATA  = 3'd2,
      ST_STOP  = 3'd4
   } uart_state_e;
`endif

   function automatic bit data_bits_ok(input int n);
      return (n >= 5) && (n <= 9);
   endfunction

   function automatic bit stop_bits_ok(input int n);
      return (n == 1) || (n == 2);
   endfunction

   // Clock cycles taken by one complete frame on the line
   function automatic int frame_cycles(input int clks, input int data, input int parity, input int stop);
      return clks * (1 + data + parity + stop);
   endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Small synchronous first-word-fall-through FIFO; a push into a full FIFO
// is accepted only when a pop happens on the same edge.
module uart_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("uart_sync_fifo: DEPTH must be a power of 2 and at least 2");
   end

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    rptr;
   logic [AW-1:0]    wptr;
   logic [AW:0]      count;
   logic             doPush;
   logic             doPop;

   assign full   = (count == (AW+1)'(DEPTH));
   assign empty  = (count == '0);
   assign doPop  = pop && !empty;
   assign doPush = push && (!full || doPop);
   assign rdata  = mem[rptr];

   always_ff @(posedge clk) begin
      if (doPush) mem[wptr] <= wdata;
   end

   // Pointers wrap naturally because DEPTH is a power of 2
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rptr  <= '0;
         wptr  <= '0;
         count <= '0;
      end else begin
         if (doPush) wptr <= wptr + 1'b1;
         if (doPop)  rptr <= rptr + 1'b1;
         if (doPush && !doPop)      count <= count + 1'b1;
         else if (doPop && !doPush) count <= count - 1'b1;
      end
   end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter draining a small FIFO back to back, LSB first.
// Optional parity bit after the data bits when UART_TX_PARITY_EN is defined.
module uart_tx_fifo
   import uart_pkg::*;
#(
   parameter int DATA_BITS    = 8,
   parameter int CLKS_PER_BIT = 4,
   parameter int STOP_BITS    = 1,
   parameter int FIFO_DEPTH   = 4,
   parameter int PARITY_ODD   = 0
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 enable,
   input  logic                 start,
   input  logic [DATA_BITS-1:0] in,
   output logic                 out,
   output logic                 busy,
   output logic                 done,
   output logic                 full,
   output logic                 overflow
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int DW = $clog2(DATA_BITS);
   localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
   localparam logic [DW-1:0] DATA_LAST = DW'(DATA_BITS - 1);
   localparam logic          STOP_LAST = (STOP_BITS == 2);

   if (!data_bits_ok(DATA_BITS)) begin : g_bad_data
      $error("uart_tx_fifo: DATA_BITS must be 5..9");
   end
   if (!stop_bits_ok(STOP_BITS)) begin : g_bad_stop
      $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
   end
   if ((CLKS_PER_BIT < 2) || ((PARITY_ODD != 0) && (PARITY_ODD != 1))) begin : g_bad_misc
      $error("uart_tx_fifo: CLKS_PER_BIT must be >= 2 and PARITY_ODD 0 or 1");
   end

   uart_state_e          state, stateNext;
   logic [CW-1:0]        cnt, cntNext;
   logic [DW-1:0]        idx, idxNext;
   logic                 stopIdx, stopIdxNext;
   logic [DATA_BITS-1:0] shreg, shregNext;
   logic [DATA_BITS-1:0] head;
   logic                 outNext;
   logic                 busyNext;
   logic                 pop;
   logic                 empty;
   logic                 pushOk;
`ifdef UART_TX_PARITY_EN
   localparam logic PAR_ODD = (PARITY_ODD != 0);
   logic par, parNext;
`endif

   uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (start),
      .pop   (pop),
      .wdata (in),
      .rdata (head),
      .full  (full),
      .empty (empty)
   );

   assign pushOk = start && (!full || pop);

   // Next-state logic: everything advances only on enabled cycles, and the
   // line level is registered so it changes on the edge that enters a bit.
   always_comb begin
      stateNext   = state;
      cntNext     = cnt;
      idxNext     = idx;
      stopIdxNext = stopIdx;
      shregNext   = shreg;
      outNext     = out;
      pop         = 1'b0;
      done        = 1'b0;
`ifdef UART_TX_PARITY_EN
      parNext     = par;
`endif
      if (enable) begin
         if (state != ST_IDLE) cntNext = (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
         case (state)
            ST_IDLE: begin
               if (!empty) begin
                  pop       = 1'b1;
                  shregNext = head;
                  outNext   = 1'b0;
                  cntNext   = '0;
                  stateNext = ST_START;
`ifdef UART_TX_PARITY_EN
                  parNext   = ^head ^ PAR_ODD;
`endif
               end
            end
            ST_START: begin
               if (cnt == CNT_LAST) begin
                  stateNext = ST_DATA;
                  idxNext   = '0;
                  outNext   = shreg[0];
               end
            end
            ST_DATA: begin
               if (cnt == CNT_LAST) begin
                  if (idx == DATA_LAST) begin
`ifdef UART_TX_PARITY_EN
                     stateNext = ST_PARITY;
                     outNext   = par;
`else
                     stateNext   = ST_STOP;
                     stopIdxNext = 1'b0;
                     outNext     = 1'b1;
`endif
                  end else begin
                     idxNext   = idx + 1'b1;
                     shregNext = {1'b0, shreg[DATA_BITS-1:1]};
                     outNext   = shreg[1];
                  end
               end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
               if (cnt == CNT_LAST) begin
                  stateNext   = ST_STOP;
                  stopIdxNext = 1'b0;
                  outNext     = 1'b1;
               end
            end
`endif
            ST_STOP: begin
               if (cnt == CNT_LAST) begin
                  if (stopIdx == STOP_LAST) begin
                     done = 1'b1;
                     if (!empty) begin
                        pop       = 1'b1;
                        shregNext = head;
                        outNext   = 1'b0;
                        stateNext = ST_START;
`ifdef UART_TX_PARITY_EN
                        parNext   = ^head ^ PAR_ODD;
`endif
                     end else begin
                        stateNext = ST_IDLE;
                        outNext   = 1'b1;
                     end
                  end else begin
                     stopIdxNext = 1'b1;
                  end
               end
            end
            default: stateNext = ST_IDLE;
         endcase
      end
      // A pop always leaves the FSM out of IDLE, so this tracks next-cycle occupancy
      busyNext = (stateNext != ST_IDLE) || !empty || pushOk;
   end

   // State, datapath and sticky flags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         cnt      <= '0;
         idx      <= '0;
         stopIdx  <= 1'b0;
         shreg    <= '0;
         out      <= 1'b1;
         busy     <= 1'b0;
         overflow <= 1'b0;
`ifdef UART_TX_PARITY_EN
         par      <= 1'b0;
`endif
      end else begin
         state    <= stateNext;
         cnt      <= cntNext;
         idx      <= idxNext;
         stopIdx  <= stopIdxNext;
         shreg    <= shregNext;
         out      <= outNext;
         busy     <= busyNext;
         overflow <= overflow | (start && !pushOk);
`ifdef UART_TX_PARITY_EN
         par      <= parNext;
`endif
      end
   end

endmodule
